// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 UART receiver feeding a one-entry valid/ready output register.
//
// Ports:
//   clock         system clock
//   reset         asynchronous, active-high reset
//   io_rx         serial line, idle high, asynchronous to clock
//   io_enable     receiver enable; low in any non-idle state aborts the frame
//   io_out_valid  a received byte is held in the output register
//   io_out_ready  consumer accepts the held byte
//   io_out_bits   received byte
//   io_frame_err  one-cycle pulse: stop bit sampled low
//   io_overrun    one-cycle pulse: byte dropped because the output register was full
//   io_busy       receiver is not idle
//
// CLKS_PER_BIT must be 4 or more.

`timescale 1ns/1ps

module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_rx,
    input  logic       io_enable,
    output logic       io_out_valid,
    input  logic       io_out_ready,
    output logic [7:0] io_out_bits,
    output logic       io_frame_err,
    output logic       io_overrun,
    output logic       io_busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfTarget = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullTarget = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e          state_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shreg_q;
    logic            valid_q;
    logic [7:0]      bits_q;
    logic            frame_err_q;
    logic            overrun_q;

    logic [CntW-1:0] target;
    logic            sample;
    logic            deliver;

    // Two-flop synchronizer; reset to the idle (high) line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= io_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Start bit is checked at its middle; every later sample is a full bit period on.
    always_comb begin
        target  = (state_q == StStart) ? HalfTarget : FullTarget;
        sample  = (cnt_q == target);
        deliver = io_enable && (state_q == StStop) && sample && rx_s_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            valid_q     <= 1'b0;
            bits_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Output register: a delivery may coincide with the consumer taking the old byte.
            if (valid_q && io_out_ready) begin
                valid_q <= 1'b0;
            end
            if (deliver) begin
                if (!valid_q || io_out_ready) begin
                    bits_q  <= shreg_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            if ((state_q != StIdle) && !io_enable) begin
                // Silent abort: no delivery, no error, output register untouched.
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (io_enable && !rx_s_q) begin
                            state_q <= StStart;
                            cnt_q   <= '0;
                        end
                    end
                    StStart: begin
                        if (sample) begin
                            cnt_q <= '0;
                            if (rx_s_q) begin
                                state_q <= StIdle;  // false start
                            end else begin
                                state_q <= StData;
                                idx_q   <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    StData: begin
                        if (sample) begin
                            cnt_q          <= '0;
                            shreg_q[idx_q] <= rx_s_q;
                            if (idx_q == 3'd7) begin
                                state_q <= StStop;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    StStop: begin
                        if (sample) begin
                            cnt_q <= '0;
                            // Leaving at mid-stop-bit leaves half a bit to catch the next start.
                            if (rx_s_q) begin
                                state_q <= StIdle;
                            end else begin
                                state_q     <= StWaitHigh;
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    StWaitHigh: begin
                        // A held-low line (break) must not be mistaken for new start bits.
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign io_out_valid = valid_q;
    assign io_out_bits  = bits_q;
    assign io_frame_err = frame_err_q;
    assign io_overrun   = overrun_q;
    assign io_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 64 clocks per bit.

`timescale 1ns/1ps

module tb_uart_rx_deserializer;

    localparam int unsigned Cpb = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_rx = 1'b1;
    logic       io_enable = 1'b1;
    logic       io_out_ready = 1'b1;
    logic       io_out_valid;
    logic [7:0] io_out_bits;
    logic       io_frame_err;
    logic       io_overrun;
    logic       io_busy;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    logic [7:0] got[$];
    int         rise_cyc[$];
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    int         busy_cnt = 0;
    int         vhigh_cnt = 0;
    logic       valid_prev = 1'b0;

    int b_got, b_rise, b_err, b_ovr, b_busy, b_vh, t0, lat, bdelta;

    uart_rx_deserializer #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_rx       (io_rx),
        .io_enable   (io_enable),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_out_bits (io_out_bits),
        .io_frame_err(io_frame_err),
        .io_overrun  (io_overrun),
        .io_busy     (io_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Observe just after the falling edge, once that edge's input changes have settled.
    always @(negedge clock) begin
        #1;
        if (io_out_valid && io_out_ready) got.push_back(io_out_bits);
        if (io_out_valid && !valid_prev) rise_cyc.push_back(cyc);
        valid_prev = io_out_valid;
        if (io_out_valid) vhigh_cnt++;
        if (io_frame_err) err_cnt++;
        if (io_overrun) ovr_cnt++;
        if (io_busy) busy_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive_bit(input logic v);
        io_rx = v;
        repeat (Cpb) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic snap();
        b_got  = got.size();
        b_rise = rise_cyc.size();
        b_err  = err_cnt;
        b_ovr  = ovr_cnt;
        b_busy = busy_cnt;
        b_vh   = vhigh_cnt;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_valid", io_out_valid, 1'b0);
        check("rst_bits", io_out_bits, 8'h00);
        check("rst_busy", io_busy, 1'b0);
        check("rst_frame_err", io_frame_err, 1'b0);
        check("rst_overrun", io_overrun, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // 1: four back-to-back frames, consumer always ready
        snap();
        t0 = cyc;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        repeat (20) @(negedge clock);
        check("t1_count", got.size() - b_got, 4);
        for (int i = 0; i < 4; i++) check("t1_byte", got[b_got + i], i + 1);
        lat = rise_cyc[b_rise] - t0;
        // 2 + 1 + Cpb/2 + 9*Cpb + 1 = 612, with +/-2 tolerance
        check("t1_latency_in_window", (lat >= 610 && lat <= 614), 1'b1);
        check("t1_spacing", rise_cyc[b_rise + 1] - rise_cyc[b_rise], 10 * Cpb);
        check("t1_valid_cycles", vhigh_cnt - b_vh, 4);
        check("t1_no_err", err_cnt - b_err, 0);
        check("t1_no_ovr", ovr_cnt - b_ovr, 0);

        // 2: overrun while consumer stalls
        io_out_ready = 1'b0;
        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (10) @(negedge clock);
        check("t2_valid_held", io_out_valid, 1'b1);
        check("t2_bits_held", io_out_bits, 8'hA5);
        check("t2_overrun_once", ovr_cnt - b_ovr, 1);
        check("t2_none_taken", got.size() - b_got, 0);
        io_out_ready = 1'b1;
        @(negedge clock);
        io_out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("t2_valid_cleared", io_out_valid, 1'b0);
        check("t2_taken_count", got.size() - b_got, 1);
        check("t2_taken_byte", got[got.size() - 1], 8'hA5);
        check("t2_bits_kept", io_out_bits, 8'hA5);
        io_out_ready = 1'b1;

        // 3: framing error then a 20-bit break, then a good frame
        snap();
        send_byte(8'h55, 1'b0);
        io_rx = 1'b0;
        repeat (20 * Cpb) @(negedge clock);
        check("t3_busy_in_break", io_busy, 1'b1);
        check("t3_frame_err_once", err_cnt - b_err, 1);
        check("t3_no_valid_in_break", rise_cyc.size() - b_rise, 0);
        io_rx = 1'b1;
        repeat (2 * Cpb) @(negedge clock);
        check("t3_idle_after_break", io_busy, 1'b0);
        send_byte(8'h7E, 1'b1);
        repeat (10) @(negedge clock);
        check("t3_one_valid", rise_cyc.size() - b_rise, 1);
        check("t3_byte", got[got.size() - 1], 8'h7E);
        check("t3_err_still_one", err_cnt - b_err, 1);

        // 4: short glitch on idle line is a false start
        snap();
        io_rx = 1'b0;
        repeat (10) @(negedge clock);
        io_rx = 1'b1;
        repeat (60) @(negedge clock);
        bdelta = busy_cnt - b_busy;
        // Cpb/2 = 32 busy cycles expected
        check("t4_busy_len_in_window", (bdelta >= 31 && bdelta <= 33), 1'b1);
        check("t4_idle", io_busy, 1'b0);
        check("t4_no_valid", rise_cyc.size() - b_rise, 0);
        check("t4_no_err", err_cnt - b_err, 0);

        // 5: disabled receiver, then enable dropped mid-frame, then normal frame
        io_enable = 1'b0;
        snap();
        send_byte(8'hFF, 1'b1);
        repeat (10) @(negedge clock);
        check("t5_disabled_busy", busy_cnt - b_busy, 0);
        check("t5_disabled_no_valid", rise_cyc.size() - b_rise, 0);
        io_enable = 1'b1;
        repeat (5) @(negedge clock);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        io_rx = 1'b0;
        repeat (Cpb / 2) @(negedge clock);
        check("t5_busy_before_drop", io_busy, 1'b1);
        io_enable = 1'b0;
        @(negedge clock);
        check("t5_busy_after_drop", io_busy, 1'b0);
        repeat (Cpb / 2 - 1) @(negedge clock);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        io_enable = 1'b1;
        repeat (5) @(negedge clock);
        check("t5_abort_no_valid", rise_cyc.size() - b_rise, 0);
        send_byte(8'h81, 1'b1);
        repeat (10) @(negedge clock);
        check("t5_byte", got[got.size() - 1], 8'h81);
        check("t5_one_valid", rise_cyc.size() - b_rise, 1);
        check("t5_no_err", err_cnt - b_err, 0);

        // 6: reset mid-frame with a byte held, then a clean frame
        io_out_ready = 1'b0;
        send_byte(8'h3C, 1'b1);
        repeat (5) @(negedge clock);
        check("t6_held_before_reset", io_out_valid, 1'b1);
        snap();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        io_rx = 1'b0;
        repeat (Cpb / 2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", io_out_valid, 1'b0);
        check("t6_rst_bits", io_out_bits, 8'h00);
        check("t6_rst_busy", io_busy, 1'b0);
        repeat (Cpb / 2) @(negedge clock);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        reset = 1'b0;
        io_out_ready = 1'b1;
        repeat (5) @(negedge clock);
        send_byte(8'h5A, 1'b1);
        repeat (10) @(negedge clock);
        check("t6_taken_count", got.size() - b_got, 1);
        check("t6_byte", got[got.size() - 1], 8'h5A);
        check("t6_no_err", err_cnt - b_err, 0);
        check("t6_no_ovr", ovr_cnt - b_ovr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
